// File: rtl/fifo_pop_stream_reader_pkg.sv
// Shared types and helpers for the FIFO pop stream reader and its output buffer.
package fifo_pop_stream_reader_pkg;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_count_t;

   localparam int buf_entries = 2;

   function automatic int last_index(input int pkt_len);
      return pkt_len - 1;
   endfunction

endpackage

// File: rtl/fifo_reader_skid2.sv
// Two-entry head/tail output buffer; the head drives the stream directly from flops.
// The per-word last bit is carried only when last_en is set.
module fifo_reader_skid2
   import fifo_pop_stream_reader_pkg::*;
#(
   parameter int width   = 8,
   parameter bit last_en = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_in,
   input  logic             take,
   input  logic [width-1:0] in_data,
   input  logic             in_last,
   output logic [1:0]       count,
   output logic [width-1:0] hd_data,
   output logic             hd_last
);

   buf_count_t       state_p1;
   buf_count_t       state_nxt;
   logic [width-1:0] hd_p1;
   logic [width-1:0] tl_p1;
   logic [width-1:0] hd_nxt;
   logic [width-1:0] tl_nxt;
   logic             hd_last_p1;
   logic             tl_last_p1;
   logic             hd_last_nxt;
   logic             tl_last_nxt;

   // ---- stage p1: buffer registers ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_p1   <= BUF_EMPTY;
         hd_p1      <= '0;
         tl_p1      <= '0;
         hd_last_p1 <= 1'b0;
         tl_last_p1 <= 1'b0;
      end else begin
         state_p1   <= state_nxt;
         hd_p1      <= hd_nxt;
         tl_p1      <= tl_nxt;
         hd_last_p1 <= hd_last_nxt;
         tl_last_p1 <= tl_last_nxt;
      end
   end

   always_comb begin
      state_nxt   = state_p1;
      hd_nxt      = hd_p1;
      tl_nxt      = tl_p1;
      hd_last_nxt = hd_last_p1;
      tl_last_nxt = tl_last_p1;
      case (state_p1)
         BUF_EMPTY: begin
            if (push_in) begin
               hd_nxt      = in_data;
               hd_last_nxt = in_last;
               state_nxt   = BUF_ONE;
            end
         end
         BUF_ONE: begin
            // Push and take together replace the head, sustaining one word per cycle.
            if (push_in && take) begin
               hd_nxt      = in_data;
               hd_last_nxt = in_last;
            end else if (push_in) begin
               tl_nxt      = in_data;
               tl_last_nxt = in_last;
               state_nxt   = BUF_FULL;
            end else if (take) begin
               state_nxt = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (take) begin
               hd_nxt      = tl_p1;
               hd_last_nxt = tl_last_p1;
               state_nxt   = BUF_ONE;
            end
         end
         default: begin
            state_nxt = BUF_EMPTY;
         end
      endcase
   end

   assign count   = state_p1;
   assign hd_data = hd_p1;
   assign hd_last = last_en & hd_last_p1;

endmodule

// File: rtl/fifo_pop_stream_reader.sv
// Drains a FIFO pop/empty/read_data port into a registered valid/ready stream with out_last framing.
// Define FIFO_POP_STREAM_READER_STATS_EN to add saturating word_count/stall_count outputs.
module fifo_pop_stream_reader
   import fifo_pop_stream_reader_pkg::*;
#(
   parameter int width   = 8,
   parameter int pkt_len = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [width-1:0] fifo_read_data,
   output logic             fifo_pop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_data,
   output logic             out_last,
   output logic             busy
`ifdef FIFO_POP_STREAM_READER_STATS_EN
   ,
   output logic [31:0]      word_count,
   output logic [31:0]      stall_count
`endif
);

   localparam logic [7:0] last_idx = 8'(last_index(pkt_len));

   logic [1:0] count;
   logic       take;
   logic       in_last;
   logic [7:0] pkt_cnt_p1;
   logic [7:0] pkt_nxt;

   // Popping is gated by reset so a held reset never consumes FIFO words.
   assign fifo_pop  = rst & ~fifo_empty & (count != 2'(buf_entries));
   assign out_valid = (count != 2'd0);
   assign busy      = out_valid;
   assign take      = out_valid & out_ready;

   assign pkt_nxt = (pkt_cnt_p1 == last_idx) ? 8'd0 : pkt_cnt_p1 + 8'd1;

   // An entering word is queued behind the head when count is 1, so it takes the next packet slot.
   assign in_last = (count == 2'd0) ? (pkt_cnt_p1 == last_idx) : (pkt_nxt == last_idx);

   // ---- stage p1: packet position of the head word ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_cnt_p1 <= 8'd0;
      end else if (take) begin
         pkt_cnt_p1 <= pkt_nxt;
      end
   end

   fifo_reader_skid2 #(
      .width   (width),
      .last_en (1'b1)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .push_in (fifo_pop),
      .take    (take),
      .in_data (fifo_read_data),
      .in_last (in_last),
      .count   (count),
      .hd_data (out_data),
      .hd_last (out_last)
   );

`ifdef FIFO_POP_STREAM_READER_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // ---- stage p1: statistics counters ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_count  <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if (take) begin
            word_count <= sat_inc(word_count);
         end
         if (out_valid && !out_ready) begin
            stall_count <= sat_inc(stall_count);
         end
      end
   end
`endif

endmodule

// File: doc/fifo_pop_stream_reader.md
Name: fifo_pop_stream_reader

Overview:
- Read-side companion to ff_fifo_with_reg_empty_full. It drains the FIFO's pop/empty/read_data interface and presents the words as a registered valid/ready stream.
- Contains a 2-entry output buffer, so stream outputs come straight from flops and downstream back-pressure never reaches the FIFO combinationally.
- Optionally frames the stream into fixed-length packets with out_last.
- Sits between any FIFO instance in the 07_fifo set and a downstream consumer.

Parameters:
- width, 8, data word width; must match the FIFO width.
- pkt_len, 4, words per packet for out_last generation; 1..255.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- fifo_empty  input  1  FIFO empty flag (registered in FIFO)
- fifo_read_data  input  width  FIFO head word, valid whenever fifo_empty=0
- fifo_pop  output  1  pop request to FIFO
- out_valid  output  1  stream word valid
- out_ready  input  1  downstream accepts word
- out_data  output  width  stream word
- out_last  output  1  last word of packet (qualified by out_valid)
- busy  output  1  buffer holds at least one word

Behaviour:
- Reset: clk and rst are the single clock and reset. Reset is asynchronous and active-low: rst=0 immediately clears all state.
  - Reset values: out_valid=0, out_data=0, out_last=0, busy=0, buffer count=0, packet counter=0.
  - fifo_pop is combinational, so it is 0 while fifo_empty=1.
- Buffer: 2 entries, head (hd) and tail (tl), with count in 0..2. out_valid=(count!=0). out_data and out_last come from the hd register.
- Pop rule: fifo_pop = ~fifo_empty & (count!=2).
  - fifo_pop does not depend on out_ready; there is no combinational path from out_ready.
  - A popped word is captured from fifo_read_data on the same clk edge.
- Per-edge update. push_in=fifo_pop, take=out_valid&out_ready.
  - count 0, push: hd<=word; count=1.
  - count 1, push & take: hd<=word; count=1 (full throughput: one word per cycle, latency 1 cycle from pop to out_valid).
  - count 1, push only: tl<=word; count=2.
  - count 1, take only: count=0.
  - count 2, take: hd<=tl; count=1. No push is possible at count 2.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- Data stability: out_data and out_last are stable while out_valid=1 and out_ready=0.
- Packet counter:
  - Counts 0..pkt_len-1 and increments on each take.
  - On a take at pkt_len-1 it wraps to 0.
  - out_last is computed when a word enters hd: 1 if it will be word index pkt_len-1 of its packet. Computing it at entry keeps out_last registered.
  - pkt_len=1 gives out_last=1 on every word.
- busy = (count!=0).
- Reset mid-operation: buffered words are discarded. The FIFO is not popped while rst=0, and no partial packet is resumed.
- fifo_empty toggling in any cycle is legal. The reader only samples fifo_read_data on cycles where fifo_pop=1.

Optional Feature:
- Macro: FIFO_POP_STREAM_READER_STATS_EN.
- When defined, adds output ports:
  - word_count (32): increments on each take.
  - stall_count (32): increments each cycle with out_valid=1 & out_ready=0.
  - Both saturate at all-ones and reset to 0.
- When undefined, the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package fifo_pop_stream_reader_pkg:
  - typedef buf_count_t (2-bit, values 0..2).
  - constant buf_entries=2.
  - function last_index(pkt_len) returning pkt_len-1.
- Sub-module fifo_reader_skid2: the 2-entry buffer with push_in/take/count and an enable-gated last-bit field.
- The top-level holds the pop logic, packet counter and optional stats.

Test Plan:
- Reset during traffic: count=2 with stats enabled, drive rst=0 mid-cycle -> out_valid, busy, out_last and fifo_pop drop to 0 immediately; stats reset to 0; the next packet starts at index 0.
- Basic drain: FIFO preloaded with 0x00,0x11,0x22,0x33,0x44, out_ready=1 constantly -> fifo_pop high 5 cycles; out_data 00,11,22,33,44 on 5 consecutive cycles starting 1 cycle after the first pop; out_last on 0x33 only (pkt_len=4).
- Back-pressure: 3 words available, out_ready=0 -> exactly 2 pops, then fifo_pop=0; out_data holds 0x00. Raise out_ready -> 0x00,0x11,0x22 delivered in order; the third pop occurs the cycle after the first take.
- Alternating ready (1,0,1,0...) on 8 words, pkt_len=4 -> all 8 words in order, out_last on the 4th and 8th words; with STATS_EN, word_count=8 and stall_count equals the counted ready=0 cycles.
- Sparse source: fifo_empty=0 one cycle in three, out_ready=1 -> each word appears exactly once, 1 cycle after its pop; out_valid=0 between words.
- Randomized: 1000 cycles, random FIFO push and out_ready at 50% -> a scoreboard sees identical in-order data; out_last every pkt_len takes; no fifo_pop while fifo_empty=1 or count=2.
